polyline_drawer: RTL
====================

Name: polyline_drawer

Overview:
- Parametrised successor to the fixed-script line sequencer.
- Accepts a stream of plot points through a valid/ready input and buffers them in an internal FIFO.
- Converts consecutive points into line segments and drives the existing line_drawer with a start/ready handshake and x1/y1/x2/y2.
- Supports pen-up breaks, drops points outside the screen, and counts the segments it issues.

Parameters:
- X_WIDTH, 10, width of x coordinates.
- Y_WIDTH, 9, width of y coordinates.
- DEPTH, 16, point FIFO depth; power of two, at least 2.
- SCREEN_W, 640, a point with x >= SCREEN_W is out of range.
- SCREEN_H, 480, a point with y >= SCREEN_H is out of range.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new polyline; honoured only in IDLE.
- ready  out  1  high in IDLE; polyline complete or never started.
- point_valid  in  1  input point offered.
- point_ready  out  1  input point accepted when point_valid and point_ready are both high.
- point_x  in  X_WIDTH  point x.
- point_y  in  Y_WIDTH  point y.
- point_break  in  1  pen-up: this point starts a new chain; no segment into it.
- point_last  in  1  final point of the polyline.
- x1  out  X_WIDTH  segment start x.
- y1  out  Y_WIDTH  segment start y.
- x2  out  X_WIDTH  segment end x.
- y2  out  Y_WIDTH  segment end y.
- line_drawer_start  out  1  one-cycle pulse to line_drawer.
- line_drawer_ready  in  1  line_drawer idle.
- segment_count  out  16  segments issued since the last start; saturates at 16'hFFFF.
- dropped_count  out  16  out-of-range points since the last start; saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - State IDLE, FIFO empty, have_prev=0, last_seen=0.
  - ready=1, point_ready=0, line_drawer_start=0.
  - x1, y1, x2, y2, both counters = 0.
- Reset mid-operation aborts immediately to these values. An in-flight line_drawer operation is not cancelled; the next start waits for line_drawer_ready as normal.
- start in IDLE:
  - Next cycle: ready=0, both counters cleared, have_prev=0, last_seen=0, FIFO flushed, state FETCH.
  - start outside IDLE is ignored.
- point_ready = (state != IDLE) && !fifo_full && !last_seen.
  - Accepting a point with point_last=1 sets last_seen; no further input is taken until the next start.
- FIFO: stores {x, y, break, last}.
  - Write-to-read latency is 1 cycle: a point accepted in cycle N is visible at cycle N+1.
  - A simultaneous push and pop while full is not possible, because point_ready is low when full.
  - A simultaneous push and pop while non-full is legal and leaves the fill level unchanged.
- FETCH: stays in FETCH while the FIFO is empty. When non-empty, pop one entry P:
  - P out of range: dropped_count++, have_prev=0. If P.last go DONE, else stay in FETCH.
  - Else if have_prev && !P.break: register x1,y1 = prev and x2,y2 = P, assert line_drawer_start for exactly one cycle, go SETTLE.
  - Else: prev=P, have_prev=1, no segment. If P.last go DONE, else stay in FETCH.
  - Isolated points (chain length 1) are never drawn.
- SETTLE: one cycle, ignoring line_drawer_ready, which the drawer drops one cycle after start. Then go WAIT.
- WAIT: when line_drawer_ready=1:
  - segment_count++, prev = the segment end point.
  - If that end point had last set go DONE, else go FETCH.
- x1/y1/x2/y2 are held stable from the start pulse until WAIT exits.
- DONE: one cycle, then IDLE; ready=1 from the first IDLE cycle.
- Minimum latency: with the FSM waiting in FETCH and have_prev=1, a point accepted in cycle N gives line_drawer_start high in cycle N+2.
- Widths:
  - Range compares are unsigned against SCREEN_W and SCREEN_H.
  - Counters saturate and never wrap.
  - FIFO pointers are log2(DEPTH)+1 bits and wrap naturally; full/empty come from the pointer MSB.

Test Plan:
- Reset, start, then points (0,0), (639,479), (0,479) with last on the third → two line_drawer_start pulses: (0,0)-(639,479), then (639,479)-(0,479); segment_count=2; ready returns high; frame-buffer dump shows both lines.
- Points (10,10), (20,10), (30,30) with break, (40,30) with last → two segments only: (10,10)-(20,10) and (30,30)-(40,30).
- Points (5,5), (640,5), (7,7), (8,8) with last → dropped_count=1; one segment, (7,7)-(8,8).
- Hold line_drawer_ready low for 200 cycles and offer 20 points → point_ready falls after DEPTH=16 points are buffered; no point is lost; all 19 segments are issued in order.
- Assert rst mid-WAIT, then start again → all outputs return to reset values next cycle; the second polyline completes normally.
- Pulse start while busy, and offer a point after the last-flagged point → start has no effect; the extra point is not accepted (point_ready=0).

Source files
------------

// File: rtl/polyline_drawer.sv
// Polyline drawer: buffers plot points in a FIFO and issues line segments
// between consecutive in-range points to an external line_drawer.
module polyline_drawer #(
   parameter int unsigned X_WIDTH  = 10,
   parameter int unsigned Y_WIDTH  = 9,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned SCREEN_W = 640,
   parameter int unsigned SCREEN_H = 480
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               ready,
   input  logic               point_valid,
   output logic               point_ready,
   input  logic [X_WIDTH-1:0] point_x,
   input  logic [Y_WIDTH-1:0] point_y,
   input  logic               point_break,
   input  logic               point_last,
   output logic [X_WIDTH-1:0] x1,
   output logic [Y_WIDTH-1:0] y1,
   output logic [X_WIDTH-1:0] x2,
   output logic [Y_WIDTH-1:0] y2,
   output logic               line_drawer_start,
   input  logic               line_drawer_ready,
   output logic [15:0]        segment_count,
   output logic [15:0]        dropped_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = X_WIDTH + Y_WIDTH + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SETTLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t state, state_next;

   logic [EW-1:0]      mem [DEPTH];
   logic [PW-1:0]      wptr, rptr;
   logic               fifo_empty, fifo_full, push;
   logic [EW-1:0]      head;
   logic [X_WIDTH-1:0] head_x;
   logic [Y_WIDTH-1:0] head_y;
   logic               head_brk, head_last, head_in_range;

   logic               have_prev, last_seen, seg_last;
   logic [X_WIDTH-1:0] prev_x;
   logic [Y_WIDTH-1:0] prev_y;

   logic               clear, pop, issue, drop, take_prev, seg_done;

   // FIFO status and head-of-queue decode
   assign fifo_empty    = (wptr == rptr);
   assign fifo_full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign point_ready   = (state != S_IDLE) && !fifo_full && !last_seen;
   assign push          = point_valid && point_ready;
   assign head          = mem[rptr[AW-1:0]];
   assign head_x        = head[EW-1 -: X_WIDTH];
   assign head_y        = head[Y_WIDTH+1 : 2];
   assign head_brk      = head[1];
   assign head_last     = head[0];
   assign head_in_range = (32'(head_x) < SCREEN_W) && (32'(head_y) < SCREEN_H);

   // FIFO storage write port
   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= {point_x, point_y, point_break, point_last};
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state and datapath control decode
   always_comb begin
      state_next = state;
      clear      = 1'b0;
      pop        = 1'b0;
      issue      = 1'b0;
      drop       = 1'b0;
      take_prev  = 1'b0;
      seg_done   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               clear      = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (!head_in_range) begin
                  drop = 1'b1;
                  if (head_last) state_next = S_DONE;
               end else if (have_prev && !head_brk) begin
                  issue      = 1'b1;
                  state_next = S_SETTLE;
               end else begin
                  take_prev = 1'b1;
                  if (head_last) state_next = S_DONE;
               end
            end
         end
         S_SETTLE: state_next = S_WAIT;
         S_WAIT: begin
            if (line_drawer_ready) begin
               seg_done   = 1'b1;
               state_next = seg_last ? S_DONE : S_FETCH;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Pointers, chain tracking, segment registers and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         ready             <= 1'b1;
         line_drawer_start <= 1'b0;
         wptr              <= '0;
         rptr              <= '0;
         have_prev         <= 1'b0;
         last_seen         <= 1'b0;
         seg_last          <= 1'b0;
         prev_x            <= '0;
         prev_y            <= '0;
         x1                <= '0;
         y1                <= '0;
         x2                <= '0;
         y2                <= '0;
         segment_count     <= '0;
         dropped_count     <= '0;
      end else begin
         ready             <= (state_next == S_IDLE);
         line_drawer_start <= issue;
         if (clear) begin
            wptr          <= '0;
            rptr          <= '0;
            have_prev     <= 1'b0;
            last_seen     <= 1'b0;
            segment_count <= '0;
            dropped_count <= '0;
         end else begin
            if (push) begin
               wptr <= wptr + PW'(1);
               if (point_last) last_seen <= 1'b1;
            end
            if (pop) rptr <= rptr + PW'(1);
            if (drop) begin
               have_prev <= 1'b0;
               if (dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
            end
            if (take_prev) begin
               prev_x    <= head_x;
               prev_y    <= head_y;
               have_prev <= 1'b1;
            end
            if (issue) begin
               x1       <= prev_x;
               y1       <= prev_y;
               x2       <= head_x;
               y2       <= head_y;
               seg_last <= head_last;
            end
            if (seg_done) begin
               prev_x <= x2;
               prev_y <= y2;
               if (segment_count != 16'hFFFF) segment_count <= segment_count + 16'd1;
            end
         end
      end
   end

endmodule
